fact_mmio_unit: RTL

- Memory-mapped iterative factorial accelerator on the MIPS data bus, decoded by the system address decoder next to the GPIO block.
- Software writes n and a go command, then polls status and reads the 32-bit result.
- done/err are also brought out as ports, so the system can feed them to a GPIO input word (factErr/done LEDs).

---
 rtl/fact_pkg.sv | 21 ++
 rtl/fact_mmio_unit_if.sv | 14 +
 rtl/fact_dp.sv | 35 +++
 rtl/fact_mmio_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial MMIO unit: register addresses, FSM encoding, operand limit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fact_pkg;

    localparam logic [1:0] ADDR_N    = 2'd0;
    localparam logic [1:0] ADDR_GO   = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;
    localparam logic [1:0] ADDR_RES  = 2'd3;

    // Largest n whose factorial still fits a 32-bit result
    localparam int MAX_N_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2,
        ST_ERR  = 2'd3
    } fact_state_t;

endpackage

// File: rtl/fact_mmio_unit_if.sv
// Single-port MIPS data-bus slice seen by the factorial unit (write strobe, word address, data).
// Latency: writes take effect on the sampling edge; rd is combinational from a.
// Backpressure: none; every write is accepted in the cycle it is presented.
interface fact_mmio_unit_if #(
    parameter int DATA_W = 32
) ();
    logic              we;
    logic [1:0]        a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport master (output we, output a, output wd, input  rd);
    modport slave  (input  we, input  a, input  wd, output rd);
endinterface

// File: rtl/fact_dp.sv
// Factorial datapath: cnt down-counter, running product register and truncating multiplier.
// Latency: one multiply-and-decrement per step cycle; last is combinational from cnt.
// Backpressure: none; load/step from the controlling FSM are obeyed unconditionally.
module fact_dp #(
    parameter int DATA_W = 32,
    parameter int N_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [N_W-1:0]    n,
    output logic [DATA_W-1:0] prod,
    output logic              last
);
    logic [N_W-1:0] cnt;

    // Load seeds cnt=n, prod=1; each step folds cnt into the product and counts down
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            prod <= '0;
        end else if (load) begin
            cnt  <= n;
            prod <= DATA_W'(1);
        end else if (step) begin
            prod <= prod * DATA_W'(cnt);
            cnt  <= cnt - 1'b1;
        end
    end

    // n=0 and n=1 both terminate immediately with prod=1
    assign last = (cnt <= N_W'(1));

endmodule

// File: rtl/fact_mmio_unit.sv
// Memory-mapped iterative factorial accelerator: N/GO/STATUS/RESULT registers plus control FSM.
// Latency: done after max(n,1) edges following the GO edge; err is set on the GO edge itself.
// Backpressure: none; GO while busy is silently dropped, software polls STATUS.busy.
module fact_mmio_unit
    import fact_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = MAX_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    fact_mmio_unit_if.slave  bus,
    output logic             done,
    output logic             err
);
    fact_state_t       state;
    logic [N_W-1:0]    n_reg;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] prod;
    logic              last;
    logic              busy;
    logic              go_wr;
    logic              n_wr;
    logic              n_ovf;
    logic              load;
    logic              step;
    logic              unused_wd;

    assign go_wr = bus.we && (bus.a == ADDR_GO) && bus.wd[0];
    assign n_wr  = bus.we && (bus.a == ADDR_N);
    assign busy  = (state == ST_CALC);
    assign n_ovf = (n_reg > N_W'(MAX_N));
    assign load  = go_wr && !busy && !n_ovf;
    assign step  = busy && !last;

    // Only the low N_W bits of a write are ever stored
    assign unused_wd = ^bus.wd[DATA_W-1:N_W];

    // N register is writable at any time; a running job keeps its own latched count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg <= '0;
        end else if (n_wr) begin
            n_reg <= bus.wd[N_W-1:0];
        end
    end

    // Control FSM: FIN/ERR behave like IDLE apart from the sticky flags they hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_CALC: begin
                    if (last) begin
                        result <= prod;
                        done   <= 1'b1;
                        state  <= ST_FIN;
                    end
                end
                default: begin
                    if (go_wr) begin
                        done <= 1'b0;
                        if (n_ovf) begin
                            err   <= 1'b1;
                            state <= ST_ERR;
                        end else begin
                            err   <= 1'b0;
                            state <= ST_CALC;
                        end
                    end
                end
            endcase
        end
    end

    fact_dp #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .n    (n_reg),
        .prod (prod),
        .last (last)
    );

    // Read mux: combinational from the word address
    always_comb begin
        bus.rd = '0;
        case (bus.a)
            ADDR_N:    bus.rd = DATA_W'(n_reg);
            ADDR_GO:   bus.rd = '0;
            ADDR_STAT: bus.rd = DATA_W'({busy, err, done});
            ADDR_RES:  bus.rd = result;
            default:   bus.rd = '0;
        endcase
    end

endmodule
